// File: rtl/router_pkg.sv
// Shared types and elaboration helpers for the router input controller.
package router_pkg;

    typedef enum logic [1:0] {
        PARSE = 2'd0,
        SEND  = 2'd1,
        DROP  = 2'd2
    } state_t;

    localparam int unsigned DATA_W_DEF    = 11;
    localparam int unsigned N_OUT_DEF     = 2;
    localparam int unsigned MAX_FLITS_DEF = 16;
    localparam int unsigned CNT_W_DEF     = 8;
    localparam int unsigned ONEHOT_W      = 32;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((r < 31) && ((32'd1 << r) < v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // One-hot decode of a port index; callers truncate to their port count.
    function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned idx);
        return ONEHOT_W'(1) << idx;
    endfunction

endpackage

// File: rtl/router_route_decode.sv
// Header decode: signed hop field to output port, rewritten header, illegal flag.
module router_route_decode
    import router_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned N_OUT  = N_OUT_DEF
) (
    input  logic [DATA_W-1:0]        hdr,
    output logic [clog2(N_OUT)-1:0]  port,
    output logic [DATA_W-1:0]        hdr_out,
    output logic                     illegal
);

    localparam int unsigned HOP_W  = DATA_W - 1;
    localparam int unsigned PORT_W = clog2(N_OUT);
    localparam int unsigned CW     = clog2(N_OUT - 1);

    logic [HOP_W-1:0]  hop;
    logic [HOP_W-1:0]  mag;
    logic [HOP_W-1:0]  fwd;
    logic [PORT_W-1:0] mag_port;
    logic              hop_pos;

    assign hop     = hdr[HOP_W-1:0];
    assign mag     = HOP_W'(0) - hop;
    assign hop_pos = !hop[HOP_W-1] && (hop != '0);
    // Most-negative hop has no positive magnitude, so it is reserved as illegal.
    assign illegal = hop[HOP_W-1] && (hop[HOP_W-2:0] == '0);

    // Low magnitude bits pick the down port; with a single down port it is always 0.
    generate
        if (CW == 0) begin : g_single_down
            assign mag_port = '0;
        end else begin : g_multi_down
            assign mag_port = PORT_W'(mag[CW-1:0]);
        end
    endgenerate

    // Positive hops climb through the up port; others descend by magnitude.
    always_comb begin
        port = mag_port;
        fwd  = mag >> CW;
        if (hop_pos) begin
            port = PORT_W'(N_OUT - 1);
            fwd  = hop - HOP_W'(1);
        end
    end

    assign hdr_out = {hdr[DATA_W-1], fwd};

endmodule

// File: rtl/router_input_ctrl.sv
// Per-input wormhole controller: parses headers, locks an output port until
// the tail, and drives flits through a one-entry registered output stage.
module router_input_ctrl
    import router_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned N_OUT     = N_OUT_DEF,
    parameter int unsigned MAX_FLITS = MAX_FLITS_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_empty,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_read,
    output logic [N_OUT-1:0]  out_req,
    input  logic [N_OUT-1:0]  out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              err_hop,
    output logic              err_long,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int unsigned HOP_W  = DATA_W - 1;
    localparam int unsigned PORT_W = clog2(N_OUT);
    localparam int unsigned FCNT_W = clog2(MAX_FLITS) + 1;

    state_t              state;
    logic [PORT_W-1:0]   lock_port;
    logic [FCNT_W-1:0]   flit_cnt;

    logic                out_vld;
    logic                drain;
    logic                can_load;
    logic                in_tail;
    logic [N_OUT-1:0]    port_req;
    logic [N_OUT-1:0]    dec_req;
    logic [CNT_W-1:0]    drop_inc;

    logic [PORT_W-1:0]   dec_port;
    logic [DATA_W-1:0]   dec_hdr;
    logic                dec_illegal;

    router_route_decode #(
        .DATA_W (DATA_W),
        .N_OUT  (N_OUT)
    ) u_decode (
        .hdr     (in_data),
        .port    (dec_port),
        .hdr_out (dec_hdr),
        .illegal (dec_illegal)
    );

    // Register is valid exactly when a request is raised; drain frees it this cycle.
    assign out_vld  = |out_req;
    assign drain    = |(out_req & out_ready);
    assign can_load = !out_vld || drain;
    assign in_tail  = in_data[DATA_W-1];
    assign busy     = (state != PARSE) || out_vld;
    assign port_req = N_OUT'(onehot(32'(lock_port)));
    assign dec_req  = N_OUT'(onehot(32'(dec_port)));
    assign drop_inc = (drop_cnt == '1) ? drop_cnt : drop_cnt + CNT_W'(1);

    // Pop when the flit has somewhere to go; discarded flits never wait on the output.
    always_comb begin
        in_read = 1'b0;
        if (state == DROP) begin
            in_read = !in_empty;
        end else begin
            in_read = !in_empty && can_load;
        end
    end

    // Packet FSM together with the output register, error flags and drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= PARSE;
            out_req   <= '0;
            out_data  <= '0;
            lock_port <= '0;
            flit_cnt  <= '0;
            err_hop   <= 1'b0;
            err_long  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (drain) begin
                out_req <= '0;
            end
            case (state)
                PARSE: begin
                    if (in_read) begin
                        if (dec_illegal) begin
                            err_hop  <= 1'b1;
                            drop_cnt <= drop_inc;
                            if (!in_tail) begin
                                state <= DROP;
                            end
                        end else begin
                            out_data  <= dec_hdr;
                            out_req   <= dec_req;
                            lock_port <= dec_port;
                            flit_cnt  <= FCNT_W'(1);
                            if (!in_tail) begin
                                state <= SEND;
                            end
                        end
                    end
                end
                SEND: begin
                    if (in_read) begin
                        out_req  <= port_req;
                        out_data <= in_data;
                        flit_cnt <= flit_cnt + FCNT_W'(1);
                        if (in_tail) begin
                            state <= PARSE;
                        end else if (flit_cnt == FCNT_W'(MAX_FLITS - 1)) begin
                            // Close the worm downstream and discard the rest of the packet.
                            out_data <= {1'b1, in_data[HOP_W-1:0]};
                            err_long <= 1'b1;
                            drop_cnt <= drop_inc;
                            state    <= DROP;
                        end
                    end
                end
                DROP: begin
                    if (in_read && in_tail) begin
                        state <= PARSE;
                    end
                end
                default: begin
                    state <= PARSE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_input_ctrl.sv
// Bench for router_input_ctrl: packet-level reference model plus directed vectors.
module tb_router_input_ctrl;

    localparam int unsigned DW   = 11;
    localparam int          MAXF = 4;

    logic          clk = 1'b0;
    logic          reset;

    logic          in_empty;
    logic [DW-1:0] in_data;
    logic          in_read;
    logic [1:0]    out_req;
    logic [1:0]    out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          err_hop;
    logic          err_long;
    logic [7:0]    drop_cnt;

    logic          in_empty_b;
    logic [DW-1:0] in_data_b;
    logic          in_read_b;
    logic [4:0]    out_req_b;
    logic [4:0]    out_ready_b;
    logic [DW-1:0] out_data_b;
    logic          busy_b;
    logic          err_hop_b;
    logic          err_long_b;
    logic [7:0]    drop_cnt_b;

    always #5 clk = ~clk;

    router_input_ctrl #(.DATA_W(DW), .N_OUT(2), .MAX_FLITS(MAXF), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_empty(in_empty), .in_data(in_data), .in_read(in_read),
        .out_req(out_req), .out_ready(out_ready), .out_data(out_data), .busy(busy),
        .err_hop(err_hop), .err_long(err_long), .drop_cnt(drop_cnt)
    );

    router_input_ctrl #(.DATA_W(DW), .N_OUT(5), .MAX_FLITS(16), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .in_empty(in_empty_b), .in_data(in_data_b), .in_read(in_read_b),
        .out_req(out_req_b), .out_ready(out_ready_b), .out_data(out_data_b), .busy(busy_b),
        .err_hop(err_hop_b), .err_long(err_long_b), .drop_cnt(drop_cnt_b)
    );

    typedef struct {
        int            port;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] fifo[$];
    int            xfer_cyc[$];
    logic [DW-1:0] xfer_dat[$];
    bit            exp_err_hop  = 1'b0;
    bit            exp_err_long = 1'b0;
    int            exp_drop     = 0;
    int            n_checks     = 0;
    int            n_pass       = 0;
    int            n_reads      = 0;
    int            cyc_n        = 0;
    bit            bp_window    = 1'b0;
    bit            prev_hold    = 1'b0;
    logic [1:0]    prev_req     = '0;
    logic [DW-1:0] prev_data    = '0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    endfunction

    // Reference routing with integer arithmetic on the signed hop.
    function automatic void route(input logic [DW-1:0] h, input int n_out,
                                  output bit ill, output int port, output logic [DW-1:0] fl);
        int hop;
        int mag;
        int fwd;
        hop = int'(h[DW-2:0]);
        if (hop >= 512) hop = hop - 1024;
        ill = (hop == -512);
        if (hop > 0) begin
            port = n_out - 1;
            fwd  = hop - 1;
        end else begin
            mag  = -hop;
            port = mag % (n_out - 1);
            fwd  = mag / (n_out - 1);
        end
        fl = {h[DW-1], 10'(fwd)};
    endfunction

    // Expected output stream and error bookkeeping for one whole packet.
    function automatic void model_pkt(input logic [DW-1:0] p[$]);
        bit            ill;
        int            port;
        int            nf;
        logic [DW-1:0] hdr;
        exp_t          e;
        route(p[0], 2, ill, port, hdr);
        if (ill) begin
            exp_err_hop = 1'b1;
            exp_drop++;
            return;
        end
        nf = (p.size() > MAXF) ? MAXF : p.size();
        for (int i = 0; i < nf; i++) begin
            e.port = port;
            e.data = (i == 0) ? hdr : p[i];
            if ((i == nf - 1) && (p.size() > MAXF)) e.data[DW-1] = 1'b1;
            exp_q.push_back(e);
        end
        if (p.size() > MAXF) begin
            exp_err_long = 1'b1;
            exp_drop++;
        end
    endfunction

    // After reset everything in flight is forgotten; what remains queued is fresh packets.
    function automatic void model_reset();
        logic [DW-1:0] pk[$];
        exp_q.delete();
        exp_err_hop  = 1'b0;
        exp_err_long = 1'b0;
        exp_drop     = 0;
        foreach (fifo[i]) begin
            pk.push_back(fifo[i]);
            if (fifo[i][DW-1]) begin
                model_pkt(pk);
                pk.delete();
            end
        end
    endfunction

    function automatic void drive_fifo();
        if (fifo.size() == 0) begin
            in_empty = 1'b1;
            in_data  = '0;
        end else begin
            in_empty = 1'b0;
            in_data  = fifo[0];
        end
    endfunction

    function automatic void send_pkt(input logic [DW-1:0] p[$]);
        foreach (p[i]) fifo.push_back(p[i]);
        model_pkt(p);
        drive_fifo();
    endfunction

    // Per-cycle comparison of the output interface against the model.
    function automatic void compare_cycle();
        bit   acc;
        exp_t e;
        cyc_n++;
        acc = |(out_req & out_ready);
        check("req_onehot", 32'($countones(out_req) <= 1), 32'd1);
        if (prev_hold) begin
            check("hold_req", 32'(out_req), 32'(prev_req));
            check("hold_data", 32'(out_data), 32'(prev_data));
        end
        if (bp_window && (out_req != '0) && !acc) check("stall_read", 32'(in_read), 32'd0);
        if (acc) begin
            if (exp_q.size() == 0) begin
                check("xfer_unexpected", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("xfer_port", 32'(out_req), 32'(1 << e.port));
                check("xfer_data", 32'(out_data), 32'(e.data));
                xfer_cyc.push_back(cyc_n);
                xfer_dat.push_back(out_data);
            end
        end
        prev_hold = (out_req != '0) && !acc;
        prev_req  = out_req;
        prev_data = out_data;
    endfunction

    task automatic tick();
        bit            rd;
        logic [DW-1:0] dmy;
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        rd = in_read && !in_empty && !reset;
        #1;
        if (rd) begin
            dmy = fifo.pop_front();
            n_reads++;
        end
        drive_fifo();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!((exp_q.size() == 0) && (fifo.size() == 0) && !busy) && (n < 60)) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, 32'(n < 60), 32'd1);
    endtask

    task automatic check_state(input string name);
        check({name, "_err_hop"}, 32'(err_hop), 32'(exp_err_hop));
        check({name, "_err_long"}, 32'(err_long), 32'(exp_err_long));
        check({name, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic reset_pulse();
        bit            rd;
        logic [DW-1:0] dmy;
        @(negedge clk);
        compare_cycle();
        #2 reset = 1'b1;
        #1;
        check("rst_out_req", 32'(out_req), 32'd0);
        check("rst_err_hop", 32'(err_hop), 32'd0);
        check("rst_err_long", 32'(err_long), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        model_reset();
        prev_hold = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        rd = in_read && !in_empty && !reset;
        #1;
        if (rd) begin
            dmy = fifo.pop_front();
            n_reads++;
        end
        drive_fifo();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] pk[$];
        bit            ill;
        int            port;
        logic [DW-1:0] fl;
        int            n0;

        reset       = 1'b1;
        in_empty    = 1'b1;
        in_data     = '0;
        out_ready   = 2'b11;
        in_empty_b  = 1'b1;
        in_data_b   = '0;
        out_ready_b = '0;
        #1;
        check("reset_out_req", 32'(out_req), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_in_read", 32'(in_read), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_errs", 32'({err_hop, err_long}), 32'd0);
        check("reset_drop_cnt", 32'(drop_cnt), 32'd0);

        // Hand-computed routes pin the reference model.
        route(11'h005, 2, ill, port, fl);
        check("pin_up_port", 32'(port), 32'd1);
        check("pin_up_data", 32'(fl), 32'h004);
        route(11'h7FD, 2, ill, port, fl);
        check("pin_down_port", 32'(port), 32'd0);
        check("pin_down_data", 32'(fl), 32'h403);
        route(11'h7F3, 5, ill, port, fl);
        check("pin_n5_port", 32'(port), 32'd1);
        check("pin_n5_data", 32'(fl), 32'h403);
        route(11'h200, 2, ill, port, fl);
        check("pin_illegal", 32'(ill), 32'd1);

        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        // Five-output instance: hop -13 routes to port 1 with forwarded hop 3.
        in_data_b  = 11'h7F3;
        in_empty_b = 1'b0;
        #1;
        check("n5_in_read", 32'(in_read_b), 32'd1);
        tick();
        in_empty_b = 1'b1;
        check("n5_out_req", 32'(out_req_b), 32'b00010);
        check("n5_out_data", 32'(out_data_b), 32'h403);
        tick();
        check("n5_hold_req", 32'(out_req_b), 32'b00010);

        // Three-flit packet up at full rate.
        xfer_cyc.delete();
        xfer_dat.delete();
        pk = '{11'h005, 11'h123, 11'h4AB};
        send_pkt(pk);
        wait_idle("t1");
        check("t1_count", 32'(xfer_dat.size()), 32'd3);
        if (xfer_dat.size() == 3) begin
            check("t1_d0", 32'(xfer_dat[0]), 32'h004);
            check("t1_d1", 32'(xfer_dat[1]), 32'h123);
            check("t1_d2", 32'(xfer_dat[2]), 32'h4AB);
            check("t1_rate", 32'(xfer_cyc[2] - xfer_cyc[0]), 32'd2);
        end
        check_state("t1");

        // Single-flit packet down.
        xfer_dat.delete();
        pk = '{11'h7FD};
        send_pkt(pk);
        wait_idle("t2");
        check("t2_count", 32'(xfer_dat.size()), 32'd1);
        if (xfer_dat.size() == 1) check("t2_d0", 32'(xfer_dat[0]), 32'h403);

        // Backpressure on the locked port for four cycles.
        xfer_cyc.delete();
        xfer_dat.delete();
        pk = '{11'h002, 11'h011, 11'h022, 11'h433};
        send_pkt(pk);
        tick();
        tick();
        out_ready = 2'b01;
        bp_window = 1'b1;
        repeat (4) tick();
        out_ready = 2'b11;
        bp_window = 1'b0;
        wait_idle("t3");
        check("t3_count", 32'(xfer_dat.size()), 32'd4);
        if (xfer_dat.size() == 4) begin
            check("t3_d1", 32'(xfer_dat[1]), 32'h011);
            check("t3_stall_gap", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd5);
            check("t3_resume_rate", 32'(xfer_cyc[3] - xfer_cyc[1]), 32'd2);
        end
        check_state("t3");

        // Illegal header dropped, following packet routes normally.
        xfer_dat.delete();
        n0 = n_reads;
        pk = '{11'h200, 11'h0AA, 11'h4BB};
        send_pkt(pk);
        pk = '{11'h7FD};
        send_pkt(pk);
        wait_idle("t4");
        check("t4_reads", 32'(n_reads - n0), 32'd4);
        check("t4_err_hop", 32'(err_hop), 32'd1);
        check("t4_drop", 32'(drop_cnt), 32'd1);
        check("t4_count", 32'(xfer_dat.size()), 32'd1);
        check_state("t4");

        // Over-long packet truncated at four flits.
        xfer_dat.delete();
        n0 = n_reads;
        pk = '{11'h003, 11'h010, 11'h020, 11'h030, 11'h040, 11'h450};
        send_pkt(pk);
        wait_idle("t5");
        check("t5_reads", 32'(n_reads - n0), 32'd6);
        check("t5_count", 32'(xfer_dat.size()), 32'd4);
        if (xfer_dat.size() == 4) check("t5_forced_tail", 32'(xfer_dat[3]), 32'h430);
        check("t5_err_long", 32'(err_long), 32'd1);
        check("t5_drop", 32'(drop_cnt), 32'd2);
        check_state("t5");

        // Reset mid-packet with the output register full.
        xfer_dat.delete();
        out_ready = 2'b00;
        pk = '{11'h001, 11'h0F1, 11'h0F2, 11'h4F3};
        send_pkt(pk);
        repeat (3) tick();
        check("t6_pre_req", 32'(out_req), 32'b10);
        reset_pulse();
        out_ready = 2'b11;
        wait_idle("t6");
        check("t6_count", 32'(xfer_dat.size()), 32'd3);
        if (xfer_dat.size() == 3) check("t6_new_hdr", 32'(xfer_dat[0]), 32'h0F0);
        check_state("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
